// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard controller for a five-stage in-order pipeline. It tracks the
// EX and MEM occupants and resolves memory waits, taken branches, load-use hazards and forwarding.
module pipe_ctrl #(
  parameter int ID_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_vld,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_rs1_vld,
  input  logic            id_rs2_vld,
  input  logic            id_rd_vld,
  input  logic            id_is_load,
  input  logic            id_is_mem,
  input  logic [ID_W-1:0] id_instID,
  input  logic            ex_br_taken,
  input  logic            mem_ack,
  output logic            if_stall,
  output logic            id_stall,
  output logic            ex_stall,
  output logic            id_flush,
  output logic            ex_bubble,
  output logic            pc_redirect,
  output logic [1:0]      fwd_rs1_sel,
  output logic [1:0]      fwd_rs2_sel,
  output logic [1:0]      ctrl_state,
  output logic [ID_W-1:0] ex_instID,
  output logic [15:0]     stall_cycles
);

  typedef enum logic [1:0] {
    ACT_RUN      = 2'd0,
    ACT_MEM_WAIT = 2'd1,
    ACT_TAKEN    = 2'd2,
    ACT_LOAD_USE = 2'd3
  } act_e;

  typedef struct packed {
    logic            vld;
    logic [4:0]      rd;
    logic            rd_vld;
    logic            is_load;
    logic            is_mem;
    logic [ID_W-1:0] inst_id;
  } ex_slot_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       rd_vld;
    logic       is_mem;
  } mem_slot_t;

  localparam int EX_W  = $bits(ex_slot_t);
  localparam int MEM_W = $bits(mem_slot_t);

  // Forward source for one operand; x0 and unused operands always read the regfile.
  function automatic logic [1:0] fwd_sel_f(input logic [4:0] rs, input logic rs_vld,
                                           input ex_slot_t ex, input mem_slot_t mem);
    logic [1:0] sel;
    sel = 2'b00;
    if (!rs_vld || rs == 5'd0) begin
      sel = 2'b00;
    end else if (ex.vld && ex.rd_vld && !ex.is_load && ex.rd == rs) begin
      sel = 2'b01;
    end else if (mem.vld && mem.rd_vld && mem.rd == rs) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  ex_slot_t  ex_q, ex_d;
  mem_slot_t mem_q, mem_d;
  act_e      state_q, act_s;
  logic [15:0] stall_q, stall_d;
  logic mem_wait_s, taken_s, load_use_s, rs1_hit_s, rs2_hit_s;

  // Hazard detection and priority selection of this cycle's action
  always_comb begin
    mem_wait_s = mem_q.vld & mem_q.is_mem & ~mem_ack;
    taken_s    = ex_br_taken & ex_q.vld;
    rs1_hit_s  = id_rs1_vld & (id_rs1 == ex_q.rd);
    rs2_hit_s  = id_rs2_vld & (id_rs2 == ex_q.rd);
    load_use_s = id_vld & ex_q.vld & ex_q.is_load & ex_q.rd_vld & (ex_q.rd != 5'd0)
                 & (rs1_hit_s | rs2_hit_s);
    if (mem_wait_s) begin
      act_s = ACT_MEM_WAIT;
    end else if (taken_s) begin
      act_s = ACT_TAKEN;
    end else if (load_use_s) begin
      act_s = ACT_LOAD_USE;
    end else begin
      act_s = ACT_RUN;
    end
  end

  // Control outputs and next contents of the EX/MEM slots
  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_stall    = 1'b0;
    id_flush    = 1'b0;
    ex_bubble   = 1'b0;
    pc_redirect = 1'b0;
    ex_d        = ex_q;
    mem_d       = mem_q;
    case (act_s)
      ACT_MEM_WAIT: begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_stall = 1'b1;
      end
      ACT_TAKEN: begin
        pc_redirect = 1'b1;
        id_flush    = 1'b1;
        ex_bubble   = 1'b1;
        ex_d        = ex_slot_t'({EX_W{1'b0}});
        mem_d       = '{vld: ex_q.vld, rd: ex_q.rd, rd_vld: ex_q.rd_vld, is_mem: ex_q.is_mem};
      end
      ACT_LOAD_USE: begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_bubble = 1'b1;
        ex_d      = ex_slot_t'({EX_W{1'b0}});
        mem_d     = '{vld: ex_q.vld, rd: ex_q.rd, rd_vld: ex_q.rd_vld, is_mem: ex_q.is_mem};
      end
      ACT_RUN: begin
        ex_d  = '{vld: id_vld, rd: id_rd, rd_vld: id_rd_vld, is_load: id_is_load,
                  is_mem: id_is_mem, inst_id: id_instID};
        mem_d = '{vld: ex_q.vld, rd: ex_q.rd, rd_vld: ex_q.rd_vld, is_mem: ex_q.is_mem};
      end
      default: begin
        ex_d  = ex_q;
        mem_d = mem_q;
      end
    endcase
  end

  // Stall counter counts the chosen action, so a taken branch masking a load-use never counts
  always_comb begin
    if ((act_s == ACT_MEM_WAIT || act_s == ACT_LOAD_USE) && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= ex_slot_t'({EX_W{1'b0}});
      mem_q   <= mem_slot_t'({MEM_W{1'b0}});
      state_q <= ACT_RUN;
      stall_q <= 16'd0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      state_q <= act_s;
      stall_q <= stall_d;
    end
  end

  assign fwd_rs1_sel  = fwd_sel_f(id_rs1, id_rs1_vld, ex_q, mem_q);
  assign fwd_rs2_sel  = fwd_sel_f(id_rs2, id_rs2_vld, ex_q, mem_q);
  assign ctrl_state   = state_q;
  assign ex_instID    = ex_q.vld ? ex_q.inst_id : {ID_W{1'b0}};
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed instruction-sequence table plus randomized traffic,
// both checked against an instruction-level model of the EX/MEM pipeline.
module tb_pipe_ctrl;
  localparam int ID_W = 8;

  logic clk, rst_n, id_vld, id_rs1_vld, id_rs2_vld, id_rd_vld, id_is_load, id_is_mem;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [ID_W-1:0] id_instID, ex_instID;
  logic ex_br_taken, mem_ack;
  logic if_stall, id_stall, ex_stall, id_flush, ex_bubble, pc_redirect;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel, ctrl_state;
  logic [15:0] stall_cycles;

  pipe_ctrl #(.ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld), .id_rd_vld(id_rd_vld),
    .id_is_load(id_is_load), .id_is_mem(id_is_mem), .id_instID(id_instID),
    .ex_br_taken(ex_br_taken), .mem_ack(mem_ack), .if_stall(if_stall), .id_stall(id_stall),
    .ex_stall(ex_stall), .id_flush(id_flush), .ex_bubble(ex_bubble),
    .pc_redirect(pc_redirect), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .ctrl_state(ctrl_state), .ex_instID(ex_instID), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // An in-flight instruction as the model sees it
  typedef struct packed {
    logic vld; logic [4:0] rd; logic rd_vld; logic is_load; logic is_mem; logic [7:0] id;
  } instr_t;

  typedef struct {
    logic vld; logic [4:0] rs1, rs2, rd; logic rs1v, rs2v, rdv, ld, mem, br, ack;
    logic [5:0] ctl; logic [1:0] f1, f2, st; logic [15:0] cnt;
  } tv_t;

  tv_t tv [20];
  tv_t nov;
  int n_vec = 0, n_bad = 0;
  instr_t in_ex, in_mem;
  logic [1:0] m_act, m_state;
  logic [15:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic tv_t mk(input logic vld, input logic [4:0] rs1, rs2, rd,
                             input logic rs1v, rs2v, rdv, ld, mem, br, ack,
                             input logic [5:0] ctl, input logic [1:0] f1, f2, st,
                             input logic [15:0] cnt);
    tv_t t;
    t.vld = vld; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rs1v = rs1v; t.rs2v = rs2v;
    t.rdv = rdv; t.ld = ld; t.mem = mem; t.br = br; t.ack = ack;
    t.ctl = ctl; t.f1 = f1; t.f2 = f2; t.st = st; t.cnt = cnt;
    return t;
  endfunction

  task automatic set_in(input logic vld, input logic [4:0] rs1, rs2, rd,
                        input logic rs1v, rs2v, rdv, ld, mem, br, ack);
    id_vld = vld; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_vld = rs1v;
    id_rs2_vld = rs2v; id_rd_vld = rdv; id_is_load = ld; id_is_mem = mem;
    ex_br_taken = br; mem_ack = ack;
  endtask

  // Where the ID operand should come from: the youngest older writer, never x0 or a load in EX
  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic v);
    if (!v || rs == 5'd0) return 2'd0;
    if (in_ex.vld && in_ex.rd_vld && !in_ex.is_load && in_ex.rd == rs) return 2'd1;
    if (in_mem.vld && in_mem.rd_vld && in_mem.rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_check();
    logic lu;
    lu = id_vld && in_ex.vld && in_ex.is_load && in_ex.rd_vld && in_ex.rd != 5'd0 &&
         ((id_rs1_vld && id_rs1 == in_ex.rd) || (id_rs2_vld && id_rs2 == in_ex.rd));
    if (in_mem.vld && in_mem.is_mem && !mem_ack) m_act = 2'd1;
    else if (ex_br_taken && in_ex.vld)           m_act = 2'd2;
    else if (lu)                                 m_act = 2'd3;
    else                                         m_act = 2'd0;
    chk("if_stall", 32'(if_stall), 32'(m_act == 2'd1 || m_act == 2'd3));
    chk("id_stall", 32'(id_stall), 32'(m_act == 2'd1 || m_act == 2'd3));
    chk("ex_stall", 32'(ex_stall), 32'(m_act == 2'd1));
    chk("id_flush", 32'(id_flush), 32'(m_act == 2'd2));
    chk("ex_bubble", 32'(ex_bubble), 32'(m_act == 2'd2 || m_act == 2'd3));
    chk("pc_redirect", 32'(pc_redirect), 32'(m_act == 2'd2));
    chk("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(m_fwd(id_rs1, id_rs1_vld)));
    chk("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(m_fwd(id_rs2, id_rs2_vld)));
    chk("ctrl_state", 32'(ctrl_state), 32'(m_state));
    chk("ex_instID", 32'(ex_instID), 32'(in_ex.vld ? in_ex.id : 8'd0));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
  endtask

  task automatic model_update();
    if ((m_act == 2'd1 || m_act == 2'd3) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (m_act != 2'd1) begin
      in_mem = in_ex;
      in_ex  = (m_act == 2'd0) ? {id_vld, id_rd, id_rd_vld, id_is_load, id_is_mem, id_instID}
                               : instr_t'(0);
    end
    m_state = m_act;
  endtask

  task automatic cycle(input bit use_tv, input tv_t v);
    @(negedge clk);
    if (use_tv) begin
      chk("tv_ctl", 32'({if_stall, id_stall, ex_stall, id_flush, ex_bubble, pc_redirect}),
          32'(v.ctl));
      chk("tv_fwd1", 32'(fwd_rs1_sel), 32'(v.f1));
      chk("tv_fwd2", 32'(fwd_rs2_sel), 32'(v.f2));
      chk("tv_state", 32'(ctrl_state), 32'(v.st));
      chk("tv_cnt", 32'(stall_cycles), 32'(v.cnt));
    end
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctl", 32'({if_stall, id_stall, ex_stall, id_flush, ex_bubble, pc_redirect}), 32'd0);
    chk("rst_fwd", 32'({fwd_rs1_sel, fwd_rs2_sel}), 32'd0);
    chk("rst_state", 32'(ctrl_state), 32'd0);
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_ex_id", 32'(ex_instID), 32'd0);
    in_ex = instr_t'(0); in_mem = instr_t'(0); m_state = 2'd0; m_cnt = 16'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    nov = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             6'd0, 2'd0, 2'd0, 2'd0, 16'd0);
    // ctl = {if_stall, id_stall, ex_stall, id_flush, ex_bubble, pc_redirect}
    tv[0]  = mk(1, 5'd1,  5'd2, 5'd5,  1, 1, 1, 0, 0, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd0);
    tv[1]  = mk(1, 5'd5,  5'd1, 5'd6,  1, 1, 1, 0, 0, 0, 1, 6'b000000, 2'd1, 2'd0, 2'd0, 16'd0);
    tv[2]  = mk(0, 5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd0);
    tv[3]  = mk(1, 5'd3,  5'd4, 5'd5,  1, 1, 1, 0, 0, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd0);
    tv[4]  = mk(0, 5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd0);
    tv[5]  = mk(1, 5'd5,  5'd1, 5'd7,  1, 1, 1, 0, 0, 0, 1, 6'b000000, 2'd2, 2'd0, 2'd0, 16'd0);
    tv[6]  = mk(1, 5'd2,  5'd0, 5'd8,  1, 0, 1, 1, 1, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd0);
    tv[7]  = mk(1, 5'd1,  5'd8, 5'd9,  1, 1, 1, 0, 0, 0, 1, 6'b110010, 2'd0, 2'd0, 2'd0, 16'd0);
    tv[8]  = mk(1, 5'd1,  5'd8, 5'd9,  1, 1, 1, 0, 0, 0, 1, 6'b000000, 2'd0, 2'd2, 2'd3, 16'd1);
    tv[9]  = mk(1, 5'd1,  5'd0, 5'd0,  1, 0, 1, 1, 1, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd1);
    tv[10] = mk(1, 5'd0,  5'd0, 5'd10, 1, 1, 1, 0, 0, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd1);
    tv[11] = mk(1, 5'd2,  5'd3, 5'd0,  1, 1, 0, 0, 1, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd1);
    tv[12] = mk(1, 5'd1,  5'd2, 5'd0,  1, 1, 0, 0, 0, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd0, 16'd1);
    tv[13] = mk(1, 5'd1,  5'd1, 5'd11, 1, 1, 1, 0, 0, 1, 0, 6'b111000, 2'd0, 2'd0, 2'd0, 16'd1);
    tv[14] = mk(1, 5'd1,  5'd1, 5'd11, 1, 1, 1, 0, 0, 1, 0, 6'b111000, 2'd0, 2'd0, 2'd1, 16'd2);
    tv[15] = mk(1, 5'd1,  5'd1, 5'd11, 1, 1, 1, 0, 0, 1, 0, 6'b111000, 2'd0, 2'd0, 2'd1, 16'd3);
    tv[16] = mk(1, 5'd1,  5'd1, 5'd11, 1, 1, 1, 0, 0, 1, 1, 6'b000111, 2'd0, 2'd0, 2'd1, 16'd4);
    tv[17] = mk(1, 5'd1,  5'd0, 5'd12, 1, 0, 1, 1, 1, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd2, 16'd4);
    tv[18] = mk(1, 5'd12, 5'd0, 5'd13, 1, 0, 1, 0, 0, 1, 1, 6'b000111, 2'd0, 2'd0, 2'd0, 16'd4);
    tv[19] = mk(0, 5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 6'b000000, 2'd0, 2'd0, 2'd2, 16'd4);

    rst_n = 1'b1;
    id_instID = 8'd0;
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      set_in(tv[i].vld, tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].rs1v, tv[i].rs2v, tv[i].rdv,
             tv[i].ld, tv[i].mem, tv[i].br, tv[i].ack);
      id_instID = 8'(i + 1);
      cycle(1'b1, tv[i]);
    end

    for (int i = 0; i < 1500; i++) begin
      logic ld;
      ld = 1'($urandom_range(0, 3) == 0);
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ld, ld | 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
      id_instID = 8'($urandom);
      cycle(1'b0, nov);
    end

    // Park a store in MEM and starve it of acks until the counter saturates
    set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 1);
    cycle(1'b0, nov);
    cycle(1'b0, nov);
    mem_ack = 1'b0;
    for (int g = 0; g < 70000 && m_cnt != 16'hFFFE; g++) cycle(1'b0, nov);
    for (int g = 0; g < 3; g++) cycle(1'b0, nov);
    @(negedge clk);
    chk("sat_cnt", 32'(stall_cycles), 32'h0000FFFF);
    do_reset();

    // Reset while a store is waiting: the access is dropped
    set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 1);
    cycle(1'b0, nov);
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1'b0, nov);
    mem_ack = 1'b0;
    cycle(1'b0, nov);
    cycle(1'b0, nov);
    do_reset();
    cycle(1'b0, nov);
    @(negedge clk);
    chk("post_rst_state", 32'(ctrl_state), 32'd0);
    chk("post_rst_stall", 32'(ex_stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
